// File: rtl/proc_control_sequencer.sv
// Multi-cycle control sequencer for the 8 x 16-bit register-file processor.
// Drives operand-mux selects, ALU op, G capture and one-hot register write-back.
module proc_control_sequencer #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 4
) (
    input  logic              wire_clock,
    input  logic              wire_resetn,
    input  logic              run,
    input  logic [DATA_W-1:0] instr_in,
    output logic              ir_load,
    output logic [SEL_W-1:0]  sel_m3,
    output logic [SEL_W-1:0]  sel_m4,
    output logic [1:0]        alu_op,
    output logic              g_load,
    output logic              wb_src,
    output logic [7:0]        reg_we,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_OPND   = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_IMM    = 3'd5
    } state_t;

    localparam logic [1:0] ALU_PASS_B = 2'b00;
    localparam logic [1:0] ALU_ADD    = 2'b01;
    localparam logic [1:0] ALU_SUB    = 2'b10;
    localparam logic [1:0] ALU_AND    = 2'b11;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  ir_q, ir_d;
    logic [SEL_W-1:0]   sel_m3_q, sel_m3_d;
    logic [SEL_W-1:0]   sel_m4_q, sel_m4_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic               g_load_q, g_load_d;
    logic               wb_src_q, wb_src_d;
    logic [7:0]         reg_we_q, reg_we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic [3:0]         opcode;
    logic [2:0]         rx;
    logic [2:0]         ry;
    logic [7:0]         rx_onehot;
    logic [1:0]         exec_op;
    logic               ir_unused;

    assign opcode    = ir_q[15:12];
    assign rx        = ir_q[10:8];
    assign ry        = ir_q[6:4];
    assign ir_unused = ^{ir_q[11], ir_q[7], ir_q[3:0]};

    for (genvar gi = 0; gi < 8; gi++) begin : g_we_dec
        assign rx_onehot[gi] = (rx == 3'(gi));
    end

    always_comb begin
        exec_op = ALU_PASS_B;
        case (opcode)
            4'd2:    exec_op = ALU_ADD;
            4'd3:    exec_op = ALU_SUB;
            4'd4:    exec_op = ALU_AND;
            default: exec_op = ALU_PASS_B;
        endcase
    end

    // Only the IR capture strobe reacts combinationally to run.
    assign ir_load = (state_q == S_IDLE) && run;

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        sel_m3_d = sel_m3_q;
        sel_m4_d = sel_m4_q;
        error_d  = error_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    ir_d    = instr_in;
                    error_d = 1'b0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                sel_m3_d = SEL_W'(rx);
                sel_m4_d = SEL_W'(ry);
                case (opcode)
                    4'd0, 4'd2, 4'd3, 4'd4: state_d = S_OPND;
                    4'd1:                   state_d = S_IMM;
                    default: begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end
            // Wait state: the external operand muxes register the selects here.
            S_OPND:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            S_IMM:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Moore outputs are decoded from the next state so they register cleanly.
        g_load_d = (state_d == S_EXEC);
        alu_op_d = (state_d == S_EXEC) ? exec_op : ALU_PASS_B;
        done_d   = (state_d == S_WB) || (state_d == S_IMM);
        reg_we_d = done_d ? rx_onehot : 8'd0;
        wb_src_d = (state_d == S_IMM);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge wire_clock or negedge wire_resetn) begin
        if (!wire_resetn) begin
            state_q  <= S_IDLE;
            ir_q     <= '0;
            sel_m3_q <= '0;
            sel_m4_q <= '0;
            alu_op_q <= ALU_PASS_B;
            g_load_q <= 1'b0;
            wb_src_q <= 1'b0;
            reg_we_q <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            sel_m3_q <= sel_m3_d;
            sel_m4_q <= sel_m4_d;
            alu_op_q <= alu_op_d;
            g_load_q <= g_load_d;
            wb_src_q <= wb_src_d;
            reg_we_q <= reg_we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign sel_m3 = sel_m3_q;
    assign sel_m4 = sel_m4_q;
    assign alu_op = alu_op_q;
    assign g_load = g_load_q;
    assign wb_src = wb_src_q;
    assign reg_we = reg_we_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;

endmodule

// File: tb/tb_proc_control_sequencer.sv
// Scoreboard bench for proc_control_sequencer: a driver predicts each accepted
// instruction's outcome, a negedge monitor pops and compares DUT responses.
module tb_proc_control_sequencer;

    logic        wire_clock = 1'b0;
    logic        wire_resetn;
    logic        run;
    logic [15:0] instr_in;
    logic        ir_load;
    logic [3:0]  sel_m3;
    logic [3:0]  sel_m4;
    logic [1:0]  alu_op;
    logic        g_load;
    logic        wb_src;
    logic [7:0]  reg_we;
    logic        busy;
    logic        done;
    logic        error;

    proc_control_sequencer #(.DATA_W(16), .SEL_W(4)) dut (
        .wire_clock (wire_clock),
        .wire_resetn(wire_resetn),
        .run        (run),
        .instr_in   (instr_in),
        .ir_load    (ir_load),
        .sel_m3     (sel_m3),
        .sel_m4     (sel_m4),
        .alu_op     (alu_op),
        .g_load     (g_load),
        .wb_src     (wb_src),
        .reg_we     (reg_we),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 wire_clock = ~wire_clock;

    int cyc = 0;
    always @(posedge wire_clock) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        int         edge_n;
        logic [7:0] we;
        logic       wb;
        logic [3:0] s3;
        logic [3:0] s4;
        logic [1:0] op;
        bit         uses_alu;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   free_at = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model: outcome of an instruction accepted at edge e.
    task automatic push_model(input logic [15:0] ins, input int e);
        exp_t x;
        int opc;
        logic [1:0] alu_tbl [5];
        alu_tbl = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        opc = int'(ins[15:12]);
        x.s3 = {1'b0, ins[10:8]};
        x.s4 = {1'b0, ins[6:4]};
        x.we = 8'd1 << ins[10:8];
        x.op = 2'd0;
        x.wb = 1'b0;
        x.uses_alu = 0;
        x.is_err = 0;
        if (opc == 1) begin
            x.edge_n = e + 1;
            x.wb = 1'b1;
            free_at = e + 3;
        end else if (opc == 0 || (opc >= 2 && opc <= 4)) begin
            x.edge_n = e + 3;
            x.uses_alu = 1;
            x.op = alu_tbl[opc];
            free_at = e + 5;
        end else begin
            x.is_err = 1;
            x.edge_n = e + 1;
            x.we = 8'd0;
            free_at = e + 2;
        end
        exp_q.push_back(x);
    endtask

    task automatic drive(input logic r, input logic [15:0] ins, input bit track);
        int e;
        @(posedge wire_clock);
        #2;
        run = r;
        instr_in = ins;
        e = cyc + 1;
        if (r && e >= free_at) begin
            acc_q.push_back(e);
            if (track) push_model(ins, e);
            else free_at = e + 5;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sel_m3"}, sel_m3, 0);
        chk({tag, "_sel_m4"}, sel_m4, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_g_load"}, g_load, 0);
        chk({tag, "_wb_src"}, wb_src, 0);
        chk({tag, "_reg_we"}, reg_we, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    // Monitor
    initial begin
        exp_t x;
        logic prev_err;
        int g_cnt;
        logic [1:0] g_op;
        prev_err = 1'b0;
        g_cnt = 0;
        g_op = 2'd0;
        forever begin
            @(negedge wire_clock);
            if (!wire_resetn) begin
                g_cnt = 0;
                prev_err = 1'b0;
            end else begin
                if (ir_load) begin
                    chk("ir_load_while_busy", busy, 0);
                    if (acc_q.size() == 0) chk("unexpected_ir_load", 1, 0);
                    else chk("accept_edge", cyc + 1, acc_q.pop_front());
                end
                if (g_load) begin
                    g_cnt++;
                    g_op = alu_op;
                end else begin
                    chk("alu_op_outside_exec", alu_op, 0);
                end
                if (!done) begin
                    chk("we_outside_wb", {23'd0, wb_src, reg_we}, 0);
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    $display("done: cyc=%0d reg_we=%02h wb_src=%0d sel=%0d/%0d", cyc, reg_we, wb_src, sel_m3, sel_m4);
                    chk("done_kind", int'(x.is_err), 0);
                    chk("done_cycle", cyc, x.edge_n);
                    chk("reg_we", reg_we, x.we);
                    chk("wb_src", wb_src, x.wb);
                    chk("sel_m3", sel_m3, x.s3);
                    chk("sel_m4", sel_m4, x.s4);
                    chk("busy_at_done", busy, 1);
                    chk("error_at_done", error, 0);
                    chk("g_load_count", g_cnt, x.uses_alu ? 1 : 0);
                    if (x.uses_alu) chk("alu_op", g_op, x.op);
                    g_cnt = 0;
                end
                if (error && !prev_err) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_error", 1, 0);
                    end else begin
                        x = exp_q.pop_front();
                        $display("error: cyc=%0d sel=%0d/%0d", cyc, sel_m3, sel_m4);
                        chk("error_kind", int'(x.is_err), 1);
                        chk("error_cycle", cyc, x.edge_n);
                        chk("error_sel_m3", sel_m3, x.s3);
                        chk("error_sel_m4", sel_m4, x.s4);
                        chk("error_g_load_count", g_cnt, 0);
                        g_cnt = 0;
                    end
                end
                prev_err = error;
            end
        end
    end

    // Stimulus
    initial begin
        logic r;
        int opc;
        logic [15:0] ins;
        wire_resetn = 1'b0;
        run = 1'b0;
        instr_in = 16'd0;
        repeat (3) @(posedge wire_clock);
        #2;
        chk("reset_ir_load", ir_load, 0);
        chk_all_zero("reset");
        wire_resetn = 1'b1;

        drive(1'b1, 16'h2120, 1'b1);
        repeat (5) drive(1'b0, 16'($urandom), 1'b1);
        drive(1'b1, 16'h1500, 1'b1);
        drive(1'b0, 16'h00AB, 1'b1);
        repeat (2) drive(1'b0, 16'($urandom), 1'b1);
        drive(1'b1, 16'h0070, 1'b1);
        repeat (5) drive(1'b0, 16'($urandom), 1'b1);
        drive(1'b1, 16'h9000, 1'b1);
        repeat (4) drive(1'b0, 16'($urandom), 1'b1);
        chk("error_sticky", error, 1);
        drive(1'b1, 16'h3434, 1'b1);
        repeat (5) drive(1'b0, 16'($urandom), 1'b1);
        repeat (12) drive(1'b1, 16'h2120, 1'b1);
        repeat (6) drive(1'b0, 16'($urandom), 1'b1);

        // Reset during EXEC of an ADD: no write-back must follow.
        drive(1'b1, 16'h2120, 1'b0);
        repeat (3) drive(1'b0, 16'h0000, 1'b1);
        chk("pre_reset_g_load", g_load, 1);
        wire_resetn = 1'b0;
        #1;
        chk_all_zero("midexec_reset");
        @(posedge wire_clock);
        #2;
        wire_resetn = 1'b1;
        free_at = 0;
        repeat (8) drive(1'b0, 16'($urandom), 1'b1);

        repeat (600) begin
            r = ($urandom_range(0, 3) != 0);
            opc = $urandom_range(0, 6);
            if (opc >= 5) opc = $urandom_range(5, 15);
            ins = {4'(opc), 12'($urandom)};
            drive(r, ins, 1'b1);
        end
        repeat (8) drive(1'b0, 16'd0, 1'b1);
        chk("pending_results", exp_q.size(), 0);
        chk("pending_accepts", acc_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
